// File: rtl/spm_ctrl_if.sv
// Operand/product handshake bundle between a producer/consumer and spm_ctrl.
interface spm_ctrl_if #(parameter int BITS = 32) ();
  logic              in_valid;
  logic              in_ready;
  logic [BITS-1:0]   in_x;
  logic [BITS-1:0]   in_a;
  logic              out_valid;
  logic              out_ready;
  logic [2*BITS-1:0] out_p;

  modport master (output in_valid, in_x, in_a, out_ready,
                  input  in_ready, out_valid, out_p);
  modport slave  (input  in_valid, in_x, in_a, out_ready,
                  output in_ready, out_valid, out_p);
endinterface

// File: rtl/spm_ctrl.sv
// Valid/ready wrapper around the bit-serial multiplier spm: serializes x, collects y.
// Optional SPM_CTRL_ZERO_SKIP_EN: zero operands bypass RUN and complete immediately.
module spm_ctrl #(
  parameter int BITS = 32
) (
  input  logic            clk,
  input  logic            rst,
  spm_ctrl_if.slave       bus,
  output logic            spm_x,
  output logic [BITS-1:0] spm_a,
  input  logic            spm_y
);
  localparam int CW = $clog2(2*BITS+1);
  localparam logic [CW-1:0] LAST  = CW'(2*BITS);
  localparam logic [CW-1:0] X_END = CW'(BITS);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     count;
  logic [BITS-1:0]   x_sh;
  logic [BITS-1:0]   a_reg;
  logic [2*BITS-1:0] p_sh;
  logic              accept;
  logic              zero_op;

  assign accept = (state == IDLE) && bus.in_valid;

`ifdef SPM_CTRL_ZERO_SKIP_EN
  assign zero_op = (bus.in_x == '0) || (bus.in_a == '0);
`else
  assign zero_op = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.in_valid) state_nxt = zero_op ? DONE : RUN;
      RUN:     if (count == LAST) state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Capture starts at count 1: spm_y lags the serialized x by one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
      x_sh  <= '0;
      a_reg <= '0;
      p_sh  <= '0;
    end else if (accept) begin
      count <= '0;
      x_sh  <= bus.in_x;
      a_reg <= bus.in_a;
      p_sh  <= '0;
    end else if (state == RUN) begin
      x_sh <= x_sh >> 1;
      if (count != LAST) count <= count + 1'b1;
      if (count != '0)   p_sh  <= {spm_y, p_sh[2*BITS-1:1]};
    end
  end

  // Zero padding after the x bits lets spm drain itself between operations.
  always_comb begin
    spm_x = 1'b0;
    if (state == RUN && count < X_END) spm_x = x_sh[0];
  end

  assign spm_a         = a_reg;
  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.out_p     = p_sh;
endmodule

// File: doc/spm_ctrl.md
Name: spm_ctrl

Overview:
Handshake front/back end for the bit-serial unsigned multiplier `spm`. It accepts a parallel operand pair over a valid/ready interface and feeds the multiplicand LSB-first into `spm.x`. It holds the multiplier on `spm.a`, deserializes the 2*BITS-bit product from `spm.y`, and presents it on a valid/ready output. It is instantiated beside one `spm` of equal width and shares its clk/rst.

Parameters:
BITS, 32, operand width; must equal the attached `spm` `bits` parameter.

Ports:
clk  input  1  clock; all state on rising edge.
rst  input  1  asynchronous, active-low reset; also wired to `spm.rst`.
in_valid  input  1  operand pair offered.
in_ready  output  1  controller can accept operands.
in_x  input  BITS  multiplicand (serialized).
in_a  input  BITS  multiplier (held parallel).
out_valid  output  1  product available.
out_ready  input  1  consumer accepts product.
out_p  output  2*BITS  unsigned product in_x*in_a.
spm_x  output  1  to `spm.x`.
spm_a  output  BITS  to `spm.a`.
spm_y  input  1  from `spm.y`.

Behaviour:
- Reset (rst low, async):
  - state=IDLE, count=0, x_sh=0, a_reg=0, p_sh=0.
  - Outputs: in_ready=1, out_valid=0, spm_x=0, spm_a=0, out_p=0.
- FSM states are IDLE, RUN and DONE; all outputs come from registers or state decode.
- IDLE:
  - in_ready=1, spm_x=0.
  - On in_valid&in_ready: x_sh<=in_x, a_reg<=in_a, count<=0, p_sh<=0; go to RUN.
- RUN:
  - in_ready=0.
  - spm_x = x_sh[0] while count<BITS, else 0; x_sh shifts right each cycle.
  - spm_a=a_reg, held stable for all of RUN.
  - When count>=1: p_sh <= {spm_y, p_sh[2*BITS-1:1]}. spm_y in RUN cycle t+1 carries product bit t.
  - count increments each cycle. At count==2*BITS (last capture) go to DONE.
- DONE:
  - out_valid=1, out_p=p_sh, held stable until out_ready.
  - On out_valid&out_ready go to IDLE. in_ready=0 in DONE; no same-cycle accept.
- Latency: out_valid rises exactly 2*BITS+1 cycles after the accepting edge (65 for BITS=32).
  - Max throughput: one product per 2*BITS+3 cycles with out_ready tied high.
- spm drain invariant:
  - After 2*BITS zero-padded cycles, all internal `spm` state is 0, because the product fits in 2*BITS bits.
  - No clear between operations is required. spm_x=0 outside RUN keeps `spm` at zero.
- Width: count is clog2(2*BITS+1) bits. The product is exact with no overflow; unsigned only.
- Boundaries:
  - in_valid held through RUN/DONE is ignored until IDLE.
  - in_x=0 or in_a=0 yields out_p=0.
  - Max operands yield (2^BITS-1)^2.
  - out_ready low indefinitely: DONE holds with out_p stable.
  - rst low mid-RUN/DONE: immediately IDLE, product discarded, `spm` cleared by the same reset.
  - in_valid and out_ready are ignored while rst is low.

Optional Feature:
Macro SPM_CTRL_ZERO_SKIP_EN.
- Defined: on accept in IDLE, if in_x==0 or in_a==0, skip RUN and go directly to DONE with p_sh=0. out_valid is then high the cycle after acceptance; spm_x stays 0.
- Undefined: every operation runs the full 2*BITS+1-cycle RUN, including zero operands.

Test Plan:
- BITS=8, in_x=3, in_a=5, out_ready=1: out_p=15 (0x000F); out_valid first high 17 cycles after accept; in_ready low throughout.
- BITS=8, in_x=0xFF, in_a=0xFF: out_p=0xFE01. Then in_x=0x01, in_a=0x80 back-to-back: out_p=0x0080, proving `spm` drained.
- Back-pressure: out_ready=0 for 10 cycles after out_valid → out_p and out_valid stable, in_ready=0. Raise out_ready → IDLE next cycle, in_ready=1.
- Reset mid-RUN at count=5, then deassert and send in_x=7, in_a=9 → out_p=63, all outputs at reset values during reset.
- Zero operand in_x=0, in_a=0xAB:
  - Without SPM_CTRL_ZERO_SKIP_EN: out_p=0 after 17 cycles.
  - With the macro: out_valid the cycle after accept, out_p=0.
- 1000 random BITS=8 and BITS=32 pairs with random in_valid/out_ready gaps → out_p equals in_x*in_a for every transaction, in order, none dropped or duplicated.
